// File: rtl/qpmm_canon.sv
// rtl/qpmm_canon.sv - reduces a redundant Montgomery product Z < 2^K*MOD to its canonical residue
// K-deep pipeline, one result per cycle, valid/tag/overflow carried alongside the data.
module qpmm_canon #(
    parameter int              W_IN  = 264,
    parameter int              W     = 254,
    parameter logic [W-1:0]    MOD   = 254'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47,
    parameter int              K     = 4,
    parameter int              TAG_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [W_IN-1:0]   in_z,
    input  logic [TAG_W-1:0]  in_tag,
    input  logic              clr_err,
    output logic              out_valid,
    output logic [W-1:0]      out_z,
    output logic [TAG_W-1:0]  out_tag,
    output logic              out_ovf,
    output logic              err_sticky,
    output logic [31:0]       out_cnt
);
    localparam int ZW = W_IN + 1;
    localparam logic [ZW-1:0] MOD_X = ZW'(MOD);
    localparam logic [ZW-1:0] LIM   = MOD_X << K;

    // Internal stages 0..K-2; the output register is the K-th registered stage.
    logic [ZW-1:0]    r_z   [0:K-2];
    logic [TAG_W-1:0] r_tag [0:K-2];
    logic             r_v   [0:K-2];
    logic             r_ovf [0:K-2];

    logic [ZW-1:0]    w_red [0:K-2];
    logic [ZW-1:0]    w_fin;

    function automatic logic [ZW-1:0] cond_sub(input logic [ZW-1:0] z, input logic [ZW-1:0] s);
        return (z >= s) ? (z - s) : z;
    endfunction

    // Stage i feeds the subtract by 2^(K-1-i)*MOD; the last one also folds in the final subtract by MOD.
    always_comb begin
        for (int i = 0; i < K - 1; i++) begin
            w_red[i] = cond_sub(r_z[i], MOD_X << (K - 1 - i));
        end
        w_fin = cond_sub(w_red[K-2], MOD_X);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < K - 1; i++) begin
                r_v[i]   <= 1'b0;
                r_ovf[i] <= 1'b0;
            end
            out_valid  <= 1'b0;
            out_z      <= '0;
            out_tag    <= '0;
            out_ovf    <= 1'b0;
            err_sticky <= 1'b0;
            out_cnt    <= '0;
        end else begin
            r_v[0]   <= in_valid;
            r_ovf[0] <= in_valid && ({1'b0, in_z} >= LIM);
            for (int i = 1; i < K - 1; i++) begin
                r_v[i]   <= r_v[i-1];
                r_ovf[i] <= r_ovf[i-1];
            end
            out_valid <= r_v[K-2];
            out_ovf   <= r_v[K-2] & r_ovf[K-2];
            if (r_v[K-2]) begin
                out_z   <= w_fin[W-1:0];
                out_tag <= r_tag[K-2];
            end
            out_cnt    <= out_cnt + {31'd0, r_v[K-2]};
            err_sticky <= (out_valid & out_ovf) | (err_sticky & ~clr_err);
        end
    end

    always_ff @(posedge clk) begin
        r_z[0]   <= {1'b0, in_z};
        r_tag[0] <= in_tag;
        for (int i = 1; i < K - 1; i++) begin
            r_z[i]   <= w_red[i-1];
            r_tag[i] <= r_tag[i-1];
        end
    end
endmodule

// File: tb/tb_qpmm_canon.sv
// tb/tb_qpmm_canon.sv - scoreboard bench for qpmm_canon against a modular-arithmetic reference
module tb_qpmm_canon;
    localparam int W_IN = 264;
    localparam int W = 254;
    localparam int K = 4;
    localparam int TAG_W = 8;
    localparam logic [W-1:0] MOD = 254'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic [W_IN-1:0]   in_z = '0;
    logic [TAG_W-1:0]  in_tag = '0;
    logic              clr_err = 1'b0;
    logic              out_valid;
    logic [W-1:0]      out_z;
    logic [TAG_W-1:0]  out_tag;
    logic              out_ovf;
    logic              err_sticky;
    logic [31:0]       out_cnt;

    qpmm_canon #(.W_IN(W_IN), .W(W), .MOD(MOD), .K(K), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_z(in_z), .in_tag(in_tag),
        .clr_err(clr_err), .out_valid(out_valid), .out_z(out_z), .out_tag(out_tag),
        .out_ovf(out_ovf), .err_sticky(err_sticky), .out_cnt(out_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]     z;
        logic [TAG_W-1:0] tag;
        logic             ovf;
    } exp_t;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_fail = 0;
    logic [31:0] n_out = 0;
    logic [31:0] n_sent = 0;

    logic [W_IN:0] mod_w;
    logic [W_IN:0] lim_w;

    task automatic chk(input string name, input logic [W_IN-1:0] act, input logic [W_IN-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The reference residue is plain modular arithmetic on the full-width value.
    task automatic send(input logic v, input logic [W_IN-1:0] z, input logic [TAG_W-1:0] tag);
        exp_t   e;
        logic [W_IN:0] zx;
        in_valid = v;
        in_z     = z;
        in_tag   = tag;
        if (v) begin
            zx    = {1'b0, z};
            e.ovf = (zx >= lim_w);
            zx    = zx % mod_w;
            e.z   = zx[W-1:0];
            e.tag = tag;
            sb.push_back(e);
            n_sent++;
        end
        step();
        in_valid = 1'b0;
    endtask

    task automatic check_latency(input logic [W_IN-1:0] z, input logic [TAG_W-1:0] tag);
        send(1'b1, z, tag);
        repeat (K - 2) step();
        chk("latency_early", {263'd0, out_valid}, 264'd0);
        step();
        chk("latency_hit", {263'd0, out_valid}, 264'd1);
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb.size() != 0 && guard < 4 * K) begin
            step();
            guard++;
        end
        chk("drain_empty", W_IN'(sb.size()), 264'd0);
        repeat (2) step();
    endtask

    function automatic logic [W_IN-1:0] rand_z();
        logic [W_IN-1:0] r;
        logic [W_IN:0]   rx;
        r = '0;
        for (int i = 0; i < 9; i++) r = {r[W_IN-33:0], $urandom()};
        rx = {1'b0, r} % lim_w;
        return rx[W_IN-1:0];
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (out_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", {263'd0, out_valid}, 264'd0);
            end else begin
                e = sb.pop_front();
                n_out = n_out + 1;
                chk("out_tag", W_IN'(out_tag), W_IN'(e.tag));
                chk("out_ovf", W_IN'(out_ovf), W_IN'(e.ovf));
                if (!e.ovf) chk("out_z", W_IN'(out_z), W_IN'(e.z));
                chk("out_cnt", W_IN'(out_cnt), W_IN'(n_out));
            end
        end
    end

    initial begin
        mod_w = (W_IN + 1)'(MOD);
        lim_w = mod_w << K;

        repeat (3) step();
        rst = 1'b0;
        chk("rst_valid", W_IN'(out_valid), 264'd0);
        chk("rst_z", W_IN'(out_z), 264'd0);
        chk("rst_tag", W_IN'(out_tag), 264'd0);
        chk("rst_ovf", W_IN'(out_ovf), 264'd0);
        chk("rst_err", W_IN'(err_sticky), 264'd0);
        chk("rst_cnt", W_IN'(out_cnt), 264'd0);

        check_latency('0, 8'h11);
        drain();

        send(1'b1, W_IN'(MOD), 8'h21);
        send(1'b1, W_IN'(MOD) - 1, 8'h22);
        send(1'b1, lim_w[W_IN-1:0] - 1, 8'h23);
        drain();

        send(1'b1, lim_w[W_IN-1:0], 8'h31);
        repeat (K - 1) step();
        chk("ovf_visible", W_IN'(out_ovf), 264'd1);
        chk("err_before", W_IN'(err_sticky), 264'd0);
        step();
        chk("err_set", W_IN'(err_sticky), 264'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("err_clear", W_IN'(err_sticky), 264'd0);
        send(1'b1, lim_w[W_IN-1:0] + 264'd7, 8'h32);
        repeat (K - 1) step();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("err_set_wins", W_IN'(err_sticky), 264'd1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        chk("err_clear2", W_IN'(err_sticky), 264'd0);
        drain();

        send(1'b1, 264'd5, 8'h41);
        send(1'b1, 264'd6, 8'h42);
        send(1'b1, 264'd7, 8'h43);
        rst = 1'b1;
        step();
        rst = 1'b0;
        sb.delete();
        n_out = 0;
        n_sent = 0;
        repeat (K + 2) step();
        chk("rst_mid_cnt", W_IN'(out_cnt), 264'd0);
        check_latency(W_IN'(MOD) + 264'd9, 8'h44);
        drain();

        for (int i = 0; i < 3000; i++) begin
            send($urandom_range(0, 3) != 0, rand_z(), TAG_W'($urandom()));
        end
        drain();
        chk("cnt_total", W_IN'(out_cnt), W_IN'(n_sent));

        force dut.out_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.out_cnt;
        n_out = 32'hFFFF_FFFF;
        send(1'b1, 264'd3, 8'h51);
        drain();
        chk("cnt_wrap", W_IN'(out_cnt), 264'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
